// File: rtl/buffered_router.sv
// Buffered router: steers one input stream into NUM_PORTS independent per-channel FIFOs.
// Optional macro BUFFERED_ROUTER_DROP_CNT_EN adds drop_cnt/drop_pulse for illegal-address beats.
module buffered_router #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = $clog2(NUM_PORTS),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            din_en,
    input  logic [ADDR_WIDTH-1:0]           addr,
    output logic                            din_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_PORTS-1:0]            dout_valid,
    input  logic [NUM_PORTS-1:0]            dout_ready,
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
    output logic [15:0]                     drop_cnt,
    output logic                            drop_pulse,
`endif
    output logic [NUM_PORTS-1:0]            fifo_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   PORTS_C = (ADDR_WIDTH + 1)'(NUM_PORTS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_PORTS];
    logic [CNT_W-1:0]      count_q  [NUM_PORTS];
    logic [CNT_W-1:0]      count_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  full_q;
    logic [NUM_PORTS-1:0]  full_d;
    logic [NUM_PORTS-1:0]  push_s;
    logic [NUM_PORTS-1:0]  pop_s;
    logic                  addr_legal_s;
    logic                  accept_s;

    // Input acceptance: illegal addresses are always accepted so they can be discarded.
    always_comb begin
        addr_legal_s = ({1'b0, addr} < PORTS_C);
        if (addr_legal_s) begin
            din_ready = !full_q[addr];
        end else begin
            din_ready = 1'b1;
        end
        accept_s = din_en && din_ready;
    end

    // Per-channel push/pop decode, next-state pointers/counts and head-of-FIFO output.
    always_comb begin
        push_s     = '0;
        pop_s      = '0;
        full_d     = '0;
        dout       = '0;
        dout_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            push_s[i] = accept_s && addr_legal_s && (addr == ADDR_WIDTH'(i));
            pop_s[i]  = (count_q[i] != '0) && dout_ready[i];
            if (push_s[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
            if (pop_s[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end
            case ({push_s[i], pop_s[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
            full_d[i] = (count_d[i] == DEPTH_C);
            // Empty channels drive zeros rather than stale RAM contents.
            if (count_q[i] != '0) begin
                dout_valid[i]                    = 1'b1;
                dout[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
            end else begin
                dout_valid[i]                    = 1'b0;
                dout[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    // Pointer, occupancy and full-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            full_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            full_q <= full_d;
        end
    end

    // Payload storage; contents are don't-care after reset since counts clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= din;
            end
        end
    end

    assign fifo_full = full_q;

`ifdef BUFFERED_ROUTER_DROP_CNT_EN
    logic        drop_s;
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_d;
    logic        drop_pulse_q;

    // Saturating count of discarded illegal-address beats.
    always_comb begin
        drop_s = accept_s && !addr_legal_s;
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter and one-cycle drop indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q   <= 16'd0;
            drop_pulse_q <= 1'b0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_s;
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign drop_pulse = drop_pulse_q;
`endif

endmodule

// File: tb/tb_buffered_router.sv
// Directed self-checking bench for buffered_router (4-port instance plus a 3-port instance for illegal addresses).
module tb_buffered_router;

    localparam int DW  = 32;
    localparam int NP  = 4;
    localparam int NP3 = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [DW-1:0]      din = '0;
    logic               din_en = 1'b0;
    logic [1:0]         addr = 2'd0;
    logic               din_ready;
    logic [NP*DW-1:0]   dout;
    logic [NP-1:0]      dout_valid;
    logic [NP-1:0]      dout_ready = '0;
    logic [NP-1:0]      fifo_full;

    logic [DW-1:0]      din3 = '0;
    logic               en3 = 1'b0;
    logic [1:0]         addr3 = 2'd0;
    logic               din_ready3;
    logic [NP3*DW-1:0]  dout3;
    logic [NP3-1:0]     dout_valid3;
    logic [NP3-1:0]     dout_ready3 = '0;
    logic [NP3-1:0]     fifo_full3;
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
    logic [15:0]        drop_cnt_a, drop_cnt3;
    logic               drop_pulse_a, drop_pulse3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffered_router #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .addr(addr),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready),
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
        .drop_cnt(drop_cnt_a), .drop_pulse(drop_pulse_a),
`endif
        .fifo_full(fifo_full)
    );

    buffered_router #(.DATA_WIDTH(DW), .NUM_PORTS(NP3), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .din(din3), .din_en(en3), .addr(addr3),
        .din_ready(din_ready3), .dout(dout3), .dout_valid(dout_valid3),
        .dout_ready(dout_ready3),
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
        .drop_cnt(drop_cnt3), .drop_pulse(drop_pulse3),
`endif
        .fifo_full(fifo_full3)
    );

    function automatic logic [DW-1:0] slice(input int i);
        return dout[i*DW +: DW];
    endfunction

    task automatic push(input logic [DW-1:0] d, input logic [1:0] a);
        din = d; addr = a; din_en = 1'b1;
        @(negedge clk);
        din_en = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++;
        if (dout_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", dout_valid); end
        checks++;
        if (fifo_full !== 4'b0000) begin errors++; $display("FAIL reset_full got %b want 0000", fifo_full); end
        for (int a = 0; a < NP; a++) begin
            addr = 2'(a); #1;
            checks++;
            if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready addr=%0d got %b want 1", a, din_ready); end
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_push;
        logic [DW-1:0] exp_v;
        dout_ready = '0;
        push(32'hA5A5_0001, 2'd2);
        checks++;
        if (dout_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b want 0100", dout_valid); end
        for (int i = 0; i < NP; i++) begin
            exp_v = (i == 2) ? 32'hA5A5_0001 : 32'h0;
            checks++;
            if (slice(i) !== exp_v) begin errors++; $display("FAIL single_slice%0d got %h want %h", i, slice(i), exp_v); end
        end
        dout_ready = 4'b0100;
        @(negedge clk);
        dout_ready = '0;
        checks++;
        if (dout_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got %b want 0000", dout_valid); end
    endtask

    task automatic test_fill_drain;
        dout_ready = '0;
        for (int k = 1; k <= 4; k++) push(DW'(k), 2'd1);
        checks++;
        if (fifo_full !== 4'b0010) begin errors++; $display("FAIL fill_full got %b want 0010", fifo_full); end
        addr = 2'd1; #1;
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL fill_ready1 got %b want 0", din_ready); end
        addr = 2'd0; #1;
        checks++;
        if (din_ready !== 1'b1) begin errors++; $display("FAIL fill_ready0 got %b want 1", din_ready); end
        push(32'h0000_0077, 2'd0);
        checks++;
        if (dout_valid !== 4'b0011) begin errors++; $display("FAIL fill_valid got %b want 0011", dout_valid); end
        checks++;
        if (slice(0) !== 32'h0000_0077) begin errors++; $display("FAIL fill_slice0 got %h want 00000077", slice(0)); end
        dout_ready = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (slice(1) !== DW'(k)) begin errors++; $display("FAIL drain_order got %h want %h", slice(1), DW'(k)); end
            @(negedge clk);
        end
        dout_ready = '0;
        checks++;
        if (dout_valid !== 4'b0000) begin errors++; $display("FAIL drain_valid got %b want 0000", dout_valid); end
        checks++;
        if (slice(1) !== 32'h0) begin errors++; $display("FAIL drain_zero got %h want 0", slice(1)); end
    endtask

    task automatic test_full_push_pop;
        dout_ready = '0;
        for (int k = 10; k <= 13; k++) push(DW'(k), 2'd3);
        checks++;
        if (fifo_full !== 4'b1000) begin errors++; $display("FAIL fullpp_full got %b want 1000", fifo_full); end
        din = 32'h0000_0099; addr = 2'd3; din_en = 1'b1; dout_ready = 4'b1000; #1;
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL fullpp_ready got %b want 0", din_ready); end
        @(negedge clk);
        din_en = 1'b0; dout_ready = '0; #1;
        checks++;
        if (fifo_full !== 4'b0000) begin errors++; $display("FAIL fullpp_notfull got %b want 0000", fifo_full); end
        checks++;
        if (din_ready !== 1'b1) begin errors++; $display("FAIL fullpp_ready_after got %b want 1", din_ready); end
        dout_ready = 4'b1000;
        for (int k = 11; k <= 13; k++) begin
            checks++;
            if (slice(3) !== DW'(k)) begin errors++; $display("FAIL fullpp_order got %h want %h", slice(3), DW'(k)); end
            @(negedge clk);
        end
        dout_ready = '0;
        checks++;
        if (dout_valid !== 4'b0000) begin errors++; $display("FAIL fullpp_empty got %b want 0000", dout_valid); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] q[$];
        logic [DW-1:0] head;
        dout_ready = '0;
        push(32'hA000_0000, 2'd0);
        push(32'hA000_0001, 2'd0);
        q.push_back(32'hA000_0000);
        q.push_back(32'hA000_0001);
        for (int k = 0; k < 10; k++) begin
            din = 32'hB000_0000 + DW'(k); addr = 2'd0; din_en = 1'b1; dout_ready = 4'b0001; #1;
            checks++;
            if (slice(0) !== q[0]) begin errors++; $display("FAIL b2b_order k=%0d got %h want %h", k, slice(0), q[0]); end
            q.push_back(din);
            void'(q.pop_front());
            @(negedge clk);
        end
        din_en = 1'b0; dout_ready = '0;
        checks++;
        if (dout_valid !== 4'b0001) begin errors++; $display("FAIL b2b_valid got %b want 0001", dout_valid); end
        dout_ready = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            head = q.pop_front();
            checks++;
            if (slice(0) !== head) begin errors++; $display("FAIL b2b_tail got %h want %h", slice(0), head); end
            @(negedge clk);
        end
        dout_ready = '0;
        checks++;
        if (dout_valid !== 4'b0000) begin errors++; $display("FAIL b2b_empty got %b want 0000", dout_valid); end
    endtask

    task automatic test_illegal_addr;
        for (int k = 1; k <= 5; k++) begin
            din3 = DW'(k); addr3 = 2'd3; en3 = 1'b1; #1;
            checks++;
            if (din_ready3 !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b want 1", din_ready3); end
            @(negedge clk);
            checks++;
            if (dout_valid3 !== 3'b000) begin errors++; $display("FAIL illegal_valid got %b want 000", dout_valid3); end
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
            checks++;
            if (drop_cnt3 !== 16'(k)) begin errors++; $display("FAIL drop_cnt got %0d want %0d", drop_cnt3, k); end
            checks++;
            if (drop_pulse3 !== 1'b1) begin errors++; $display("FAIL drop_pulse_hi got %b want 1", drop_pulse3); end
`endif
        end
        en3 = 1'b0;
        @(negedge clk);
        checks++;
        if (dout3 !== '0) begin errors++; $display("FAIL illegal_dout got %h want 0", dout3); end
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
        checks++;
        if (drop_pulse3 !== 1'b0) begin errors++; $display("FAIL drop_pulse_lo got %b want 0", drop_pulse3); end
        checks++;
        if (drop_cnt3 !== 16'd5) begin errors++; $display("FAIL drop_cnt_hold got %0d want 5", drop_cnt3); end
`endif
        din3 = 32'hC3C3_0002; addr3 = 2'd2; en3 = 1'b1;
        @(negedge clk);
        en3 = 1'b0;
        checks++;
        if (dout_valid3 !== 3'b100) begin errors++; $display("FAIL p3_valid got %b want 100", dout_valid3); end
        checks++;
        if (dout3[2*DW +: DW] !== 32'hC3C3_0002) begin errors++; $display("FAIL p3_slice2 got %h want c3c30002", dout3[2*DW +: DW]); end
        addr3 = 2'd3; en3 = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
`ifdef BUFFERED_ROUTER_DROP_CNT_EN
        checks++;
        if (drop_cnt3 !== 16'd0) begin errors++; $display("FAIL drop_cnt_rst got %0d want 0", drop_cnt3); end
`endif
        checks++;
        if (dout_valid3 !== 3'b000) begin errors++; $display("FAIL p3_rst_valid got %b want 000", dout_valid3); end
        en3 = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
        test_illegal_addr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
